// File: rtl/stream_max_pkg.sv
// rtl/stream_max_pkg.sv - shared definitions for the streaming max/argmax block
//
// Purpose: FSM state encoding and the packet-length helper used by
//          stream_max_argmax and its bench.
// Ports:   none (package).

package stream_max_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Maximum packet length for a given index width.
  function automatic int max_len(input int size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// rtl/max_cmp.sv - combinational greater-than comparator, signed or unsigned
//
// Purpose: gt = (a > b), two's-complement when SIGNED != 0.
// Ports:   a, b  [WIDTH-1:0] operands
//          gt               strict greater-than result

module max_cmp #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  generate
    if (SIGNED != 0) begin : g_signed
      assign gt = $signed(a) > $signed(b);
    end else begin : g_unsigned
      assign gt = a > b;
    end
  endgenerate

endmodule

// File: rtl/stream_max_argmax.sv
// rtl/stream_max_argmax.sv - streaming maximum / first-occurrence argmax over a packet
//
// Purpose: accepts one element per cycle until in_last, then holds a registered
//          result (max, argmax, count, overflow) until the consumer takes it.
// Ports:   clk, rst                       clock, synchronous active-high reset
//          in_valid/in_ready/in_data/in_last   element stream in
//          out_valid/out_ready            result handshake
//          out_max [WIDTH-1:0]            packet maximum
//          out_argmax [SIZE-1:0]          index of first maximum
//          out_count [SIZE:0]             element count, saturating at 2**SIZE
//          out_overflow                   packet longer than 2**SIZE elements

module stream_max_argmax
  import stream_max_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIZE   = 3,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [SIZE-1:0]  out_argmax,
  output logic [SIZE:0]    out_count,
  output logic             out_overflow
);

  localparam logic [SIZE:0] MAX_CNT = (SIZE + 1)'(max_len(SIZE));

  state_e            state_q, state_d;
  logic [SIZE:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic [SIZE-1:0]   arg_q, arg_d;
  logic [WIDTH-1:0]  out_max_q, out_max_d;
  logic [SIZE-1:0]   out_arg_q, out_arg_d;
  logic [SIZE:0]     out_cnt_q, out_cnt_d;
  logic              out_ovf_q, out_ovf_d;

  logic              gt;
  logic              take;
  logic              in_range;
  logic [WIDTH-1:0]  run_max;
  logic [SIZE-1:0]   run_arg;

  max_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a  (in_data),
    .b  (max_q),
    .gt (gt)
  );

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_max      = out_max_q;
  assign out_argmax   = out_arg_q;
  assign out_count    = out_cnt_q;
  assign out_overflow = out_ovf_q;

  assign take     = in_valid && in_ready;
  // Beats at index >= 2**SIZE are accepted but excluded from the compare;
  // the counter parks at MAX_CNT so argmax can never alias a low index.
  assign in_range = (cnt_q < MAX_CNT);

  // Running max/argmax including the current beat.
  always_comb begin
    run_max = max_q;
    run_arg = arg_q;
    if (cnt_q == '0) begin
      run_max = in_data;
      run_arg = '0;
    end else if (in_range && gt) begin
      run_max = in_data;
      run_arg = cnt_q[SIZE-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    max_d     = max_q;
    arg_d     = arg_q;
    out_max_d = out_max_q;
    out_arg_d = out_arg_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (take) begin
          max_d = run_max;
          arg_d = run_arg;
          if (in_range) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            out_max_d = run_max;
            out_arg_d = run_arg;
            out_cnt_d = in_range ? cnt_q + 1'b1 : cnt_q;
            out_ovf_d = ovf_q | ~in_range;
            // Result is captured; running state restarts for the next packet.
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      max_q     <= '0;
      arg_q     <= '0;
      out_max_q <= '0;
      out_arg_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      max_q     <= max_d;
      arg_q     <= arg_d;
      out_max_q <= out_max_d;
      out_arg_q <= out_arg_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_stream_max_argmax.sv
// tb/tb_stream_max_argmax.sv - self-checking bench for stream_max_argmax

module tb_stream_max_argmax;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready_u, out_valid_u, out_ovf_u;
  logic [7:0] out_max_u;
  logic [2:0] out_arg_u;
  logic [3:0] out_cnt_u;
  logic       in_ready_s, out_valid_s, out_ovf_s;
  logic [7:0] out_max_s;
  logic [2:0] out_arg_s;
  logic [3:0] out_cnt_s;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_max_argmax #(.WIDTH(8), .SIZE(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_max(out_max_u), .out_argmax(out_arg_u),
    .out_count(out_cnt_u), .out_overflow(out_ovf_u)
  );

  stream_max_argmax #(.WIDTH(8), .SIZE(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_max(out_max_s), .out_argmax(out_arg_s),
    .out_count(out_cnt_s), .out_overflow(out_ovf_s)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] pkt[$];
  bit         exp_hold = 1'b0;
  int         exp_max_u = 0, exp_arg_u = 0, exp_max_s = 0, exp_arg_s = 0;
  int         exp_cnt = 0;
  bit         exp_ovf = 1'b0;

  task automatic model_result();
    int n, lim, bu, bs;
    n   = pkt.size();
    lim = (n < 8) ? n : 8;
    bu  = 0;
    bs  = 0;
    for (int i = 1; i < lim; i++) begin
      if (pkt[i] > pkt[bu]) bu = i;
      if ($signed(pkt[i]) > $signed(pkt[bs])) bs = i;
    end
    exp_max_u = pkt[bu];
    exp_arg_u = bu;
    exp_max_s = pkt[bs];
    exp_arg_s = bs;
    exp_cnt   = lim;
    exp_ovf   = (n > 8);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      pkt.delete();
      exp_hold  = 1'b0;
      exp_max_u = 0; exp_arg_u = 0; exp_max_s = 0; exp_arg_s = 0;
      exp_cnt   = 0; exp_ovf = 1'b0;
    end else if (exp_hold) begin
      if (out_ready) exp_hold = 1'b0;
    end else if (in_valid) begin
      pkt.push_back(in_data);
      if (in_last) begin
        model_result();
        pkt.delete();
        exp_hold = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u_in_ready",  int'(in_ready_u),  int'(!exp_hold));
      chk("u_out_valid", int'(out_valid_u), int'(exp_hold));
      chk("u_out_max",   int'(out_max_u),   exp_max_u);
      chk("u_out_arg",   int'(out_arg_u),   exp_arg_u);
      chk("u_out_count", int'(out_cnt_u),   exp_cnt);
      chk("u_out_ovf",   int'(out_ovf_u),   int'(exp_ovf));
      chk("s_in_ready",  int'(in_ready_s),  int'(!exp_hold));
      chk("s_out_valid", int'(out_valid_s), int'(exp_hold));
      chk("s_out_max",   int'(out_max_s),   exp_max_s);
      chk("s_out_arg",   int'(out_arg_s),   exp_arg_s);
      chk("s_out_count", int'(out_cnt_s),   exp_cnt);
      chk("s_out_ovf",   int'(out_ovf_s),   int'(exp_ovf));
    end
  end

  // ---------------- stimulus helpers (called at posedge + #1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int  g;
    bit  acc;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      acc = !exp_hold;
      step();
      g++;
    end while (!acc && g < 100);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
    if (!acc) timeout_fail("send_beat");
  endtask

  task automatic wait_result();
    int g;
    g = 0;
    while (!out_valid_u && g < 50) begin
      step();
      g++;
    end
    if (!out_valid_u) timeout_fail("wait_result");
  endtask

  task automatic lit_u(input string nm, input int mx, input int ag, input int ct, input int ov);
    chk({nm, "_lit_max_u"},   int'(out_max_u), mx);
    chk({nm, "_lit_arg_u"},   int'(out_arg_u), ag);
    chk({nm, "_lit_count_u"}, int'(out_cnt_u), ct);
    chk({nm, "_lit_ovf_u"},   int'(out_ovf_u), ov);
  endtask

  task automatic lit_zero(input string nm);
    chk({nm, "_valid0"}, int'(out_valid_u), 0);
    chk({nm, "_ready1"}, int'(in_ready_u), 1);
    chk({nm, "_max0"},   int'(out_max_u), 0);
    chk({nm, "_arg0"},   int'(out_arg_u), 0);
    chk({nm, "_cnt0"},   int'(out_cnt_u), 0);
    chk({nm, "_ovf0"},   int'(out_ovf_u), 0);
  endtask

  logic [7:0] t1 [8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
  logic [7:0] t2 [8] = '{8'd50, 8'd30, 8'd80, 8'd20, 8'd80, 8'd10, 8'd80, 8'd40};
  logic [7:0] t4 [4] = '{8'hF0, 8'h05, 8'h80, 8'h7F};

  initial begin
    repeat (2) step();
    chk_en = 1'b1;
    lit_zero("reset");
    rst = 1'b0;
    out_ready = 1'b1;

    // 1: ascending
    for (int i = 0; i < 8; i++) send_beat(t1[i], i == 7);
    chk("t1_valid_next_cycle", int'(out_valid_u), 1);
    lit_u("t1", 80, 7, 8, 0);
    step();

    // 2: ties and all-equal
    for (int i = 0; i < 8; i++) send_beat(t2[i], i == 7);
    wait_result();
    lit_u("t2_ties", 80, 2, 8, 0);
    step();
    for (int i = 0; i < 8; i++) send_beat(8'd42, i == 7);
    wait_result();
    lit_u("t2_equal", 42, 0, 8, 0);
    step();

    // 3: backpressure, then single-beat packet
    out_ready = 1'b0;
    send_beat(8'd90, 1'b0);
    send_beat(8'd50, 1'b0);
    send_beat(8'd30, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("t3_held_valid", int'(out_valid_u), 1);
      chk("t3_held_ready", int'(in_ready_u), 0);
      lit_u("t3_held", 90, 0, 3, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t3_ready_after_hs", int'(in_ready_u), 1);
    chk("t3_valid_after_hs", int'(out_valid_u), 0);
    send_beat(8'd7, 1'b1);
    wait_result();
    lit_u("t3_single", 7, 0, 1, 0);
    step();

    // 4: signed vs unsigned
    for (int i = 0; i < 4; i++) send_beat(t4[i], i == 3);
    wait_result();
    chk("t4_signed_max", int'(out_max_s), 8'h7F);
    chk("t4_signed_arg", int'(out_arg_s), 3);
    lit_u("t4_unsigned", 8'hF0, 0, 4, 0);
    step();

    // 5: overflow
    for (int i = 0; i < 10; i++) begin
      chk("t5_ready", int'(in_ready_u), 1);
      send_beat((i == 8) ? 8'd255 : 8'd1, i == 9);
    end
    wait_result();
    lit_u("t5_ovf", 1, 0, 8, 1);
    step();

    // 6: reset mid-packet and in HOLD
    for (int i = 0; i < 4; i++) send_beat(8'(100 + i), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lit_zero("t6_mid");
    out_ready = 1'b0;
    send_beat(8'd200, 1'b0);
    send_beat(8'd201, 1'b1);
    chk("t6_in_hold", int'(out_valid_u), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lit_zero("t6_hold");
    out_ready = 1'b1;
    send_beat(8'd3, 1'b0);
    send_beat(8'd9, 1'b0);
    send_beat(8'd9, 1'b1);
    wait_result();
    lit_u("t6_after", 9, 1, 3, 0);
    step();

    // random packets with gaps and backpressure
    for (int p = 0; p < 60; p++) begin
      int  len, sent, guard, mode;
      bit  acc;
      len   = $urandom_range(1, 11);
      mode  = $urandom_range(0, 1);
      sent  = 0;
      guard = 0;
      while (sent < len && guard < 1000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = mode ? 8'($urandom_range(0, 3)) : 8'($urandom);
        in_last   = (sent == len - 1);
        out_ready = ($urandom_range(0, 2) != 0);
        acc = in_valid && !exp_hold;
        step();
        if (acc) sent++;
        guard++;
      end
      if (sent < len) timeout_fail("random_packet");
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
